// File: rtl/gpio_in_conditioner_if.sv
// Pin-side bus of gpio_in_conditioner: raw levels in, debounced levels, edge pulses and sticky events out.
// The IRQ signals exist only when GPIO_IN_CONDITIONER_IRQ_EN is defined.
interface gpio_in_conditioner_if #(
  parameter int NumInputs = 3
);
  logic [NumInputs-1:0] raw_i;
  logic [NumInputs-1:0] stable_o;
  logic [NumInputs-1:0] rise_o;
  logic [NumInputs-1:0] fall_o;
  logic [NumInputs-1:0] event_o;
  logic [NumInputs-1:0] event_clr_i;
`ifdef GPIO_IN_CONDITIONER_IRQ_EN
  logic [NumInputs-1:0] irq_mask_i;
  logic                 irq_o;

  modport master (
    output raw_i, event_clr_i, irq_mask_i,
    input  stable_o, rise_o, fall_o, event_o, irq_o
  );
  modport slave (
    input  raw_i, event_clr_i, irq_mask_i,
    output stable_o, rise_o, fall_o, event_o, irq_o
  );
`else
  modport master (
    output raw_i, event_clr_i,
    input  stable_o, rise_o, fall_o, event_o
  );
  modport slave (
    input  raw_i, event_clr_i,
    output stable_o, rise_o, fall_o, event_o
  );
`endif
endinterface

// File: rtl/gpio_in_conditioner.sv
// Push-button input conditioner: 2-flop sync, per-channel debounce, rise/fall pulses, sticky events.
// Optional masked interrupt output when GPIO_IN_CONDITIONER_IRQ_EN is defined.
module gpio_in_conditioner #(
  parameter int NumInputs      = 3,
  parameter int DebounceCycles = 60000,
  parameter bit InvertInputs   = 1'b0
) (
  input logic                  clk_i,
  input logic                  rst_i,
  gpio_in_conditioner_if.slave bus
);
  localparam int              CntW     = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] Terminal = CntW'(DebounceCycles - 1);

  logic [NumInputs-1:0] pin;
  logic [NumInputs-1:0] sync_q1, sync_q2;
  logic [NumInputs-1:0] stable_q, rise_q, fall_q, event_q;
  logic [NumInputs-1:0] stable_d, rise_d, fall_d, event_d;
  logic [CntW-1:0]      cnt_q [NumInputs];
  logic [CntW-1:0]      cnt_d [NumInputs];

  assign pin = bus.raw_i ^ {NumInputs{InvertInputs}};

  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < NumInputs; i++) begin
      cnt_d[i] = '0;
      if (sync_q2[i] != stable_q[i]) begin
        if (cnt_q[i] == Terminal) begin
          stable_d[i] = sync_q2[i];
          rise_d[i]   = sync_q2[i];
          fall_d[i]   = ~sync_q2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    // A new edge outranks a clear arriving on the same cycle.
    event_d = (event_q & ~bus.event_clr_i) | rise_d | fall_d;
  end

  // NOTE: sequential state uses non-blocking assignments only; the counter array is small
  // per-channel state, not a RAM, so it is reset along with everything else.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q1  <= '0;
      sync_q2  <= '0;
      stable_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      event_q  <= '0;
      for (int i = 0; i < NumInputs; i++) cnt_q[i] <= '0;
    end else begin
      sync_q1  <= pin;
      sync_q2  <= sync_q1;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      event_q  <= event_d;
      for (int i = 0; i < NumInputs; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.stable_o = stable_q;
  assign bus.rise_o   = rise_q;
  assign bus.fall_o   = fall_q;
  assign bus.event_o  = event_q;

`ifdef GPIO_IN_CONDITIONER_IRQ_EN
  logic irq_q;

  // Built from event_d so the interrupt lines up with the event bit it reports.
  always_ff @(posedge clk_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= |(event_d & bus.irq_mask_i);
  end

  assign bus.irq_o = irq_q;
`endif
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner: dut_a plain inputs, dut_b inverted inputs, both DebounceCycles=4.
// IRQ checks are compiled only when GPIO_IN_CONDITIONER_IRQ_EN is defined.
module tb_gpio_in_conditioner;
  localparam int N = 3;
  localparam int D = 4;
  localparam int L = D + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gpio_in_conditioner_if #(.NumInputs(N)) bus_a ();
  gpio_in_conditioner_if #(.NumInputs(N)) bus_b ();

  gpio_in_conditioner #(.NumInputs(N), .DebounceCycles(D), .InvertInputs(1'b0)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a)
  );
  gpio_in_conditioner #(.NumInputs(N), .DebounceCycles(D), .InvertInputs(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b)
  );

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_stable;
  logic [N-1:0] exp_event;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Change one channel of dut_a and walk through the debounce window, optionally
  // asserting that channel's clear on the very edge the new level is accepted.
  task automatic settle(input string tag, input int idx, input logic lvl, input bit collide);
    logic [N-1:0] bitm;
    logic [N-1:0] old_s;
    bitm = N'(1) << idx;
    old_s = exp_stable;
    bus_a.raw_i[idx] = lvl;
    for (int k = 1; k <= L; k++) begin
      if (collide && k == L) bus_a.event_clr_i = bitm;
      tick();
      if (k < L) begin
        check({tag, "_hold"}, bus_a.stable_o, old_s);
        check({tag, "_nopulse"}, bus_a.rise_o | bus_a.fall_o, 0);
      end else begin
        exp_stable = lvl ? (old_s | bitm) : (old_s & ~bitm);
        exp_event  = exp_event | bitm;
        check({tag, "_stable"}, bus_a.stable_o, exp_stable);
        check({tag, "_rise"}, bus_a.rise_o, lvl ? bitm : '0);
        check({tag, "_fall"}, bus_a.fall_o, lvl ? '0 : bitm);
        check({tag, "_event"}, bus_a.event_o, exp_event);
      end
    end
    bus_a.event_clr_i = '0;
  endtask

  task automatic clear(input string tag, input logic [N-1:0] m);
    bus_a.event_clr_i = m;
    tick();
    bus_a.event_clr_i = '0;
    exp_event = exp_event & ~m;
    check(tag, bus_a.event_o, exp_event);
  endtask

  initial begin
    rst = 1'b1;
    bus_a.raw_i = 3'b111;
    bus_b.raw_i = 3'b000;
    bus_a.event_clr_i = '0;
    bus_b.event_clr_i = '0;
`ifdef GPIO_IN_CONDITIONER_IRQ_EN
    bus_a.irq_mask_i = 3'b010;
    bus_b.irq_mask_i = 3'b000;
`endif

    // Reset held for three edges: everything stays zero.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_stable", bus_a.stable_o, 0);
      check("rst_pulses", {bus_a.rise_o, bus_a.fall_o}, 0);
      check("rst_event", bus_a.event_o, 0);
      check("rst_stable_inv", bus_b.stable_o, 0);
`ifdef GPIO_IN_CONDITIONER_IRQ_EN
      check("rst_irq", bus_a.irq_o, 0);
`endif
    end
    rst = 1'b0;

    // Release: both DUTs see all-ones after D+2 edges.
    for (int k = 1; k <= L; k++) begin
      tick();
      check("rel_stable", bus_a.stable_o, (k == L) ? 3'b111 : 3'b000);
      check("rel_stable_inv", bus_b.stable_o, (k == L) ? 3'b111 : 3'b000);
    end
    check("rel_rise", bus_a.rise_o, 3'b111);
    check("rel_fall", bus_a.fall_o, 3'b000);
    check("rel_event", bus_a.event_o, 3'b111);
    check("rel_rise_inv", bus_b.rise_o, 3'b111);
    tick();
    check("rel_rise_once", bus_a.rise_o, 3'b000);
    check("rel_event_sticky", bus_a.event_o, 3'b111);
    exp_stable = 3'b111;
    exp_event  = 3'b111;
    clear("clr_all", 3'b111);

    // Clean release then press on channel 0.
    settle("ch0_fall", 0, 1'b0, 1'b0);
    settle("ch0_rise", 0, 1'b1, 1'b0);

    // Channel 1 low, then bouncing every 2 cycles, then a steady high.
    settle("ch1_fall", 1, 1'b0, 1'b0);
    for (int seg = 0; seg < 4; seg++) begin
      bus_a.raw_i[1] = (seg % 2 == 0);
      for (int k = 0; k < 2; k++) begin
        tick();
        check("bounce_hold", bus_a.stable_o, exp_stable);
        check("bounce_nopulse", bus_a.rise_o | bus_a.fall_o, 0);
      end
    end
    settle("ch1_rise", 1, 1'b1, 1'b0);

    // Sticky flag on channel 2: clear alone, then clear colliding with a new fall.
    settle("ch2_fall", 2, 1'b0, 1'b0);
    clear("ch2_clr", 3'b100);
    settle("ch2_rise", 2, 1'b1, 1'b0);
    clear("ch2_clr2", 3'b100);
    settle("ch2_collide", 2, 1'b0, 1'b1);
    tick();
    check("ch2_collide_kept", bus_a.event_o, exp_event);

    // Inverted DUT: a high pin means a released button.
    bus_b.raw_i[0] = 1'b1;
    for (int k = 1; k <= L; k++) begin
      tick();
      check("inv_stable", bus_b.stable_o, (k == L) ? 3'b110 : 3'b111);
    end
    check("inv_fall", bus_b.fall_o, 3'b001);
    check("inv_rise", bus_b.rise_o, 3'b000);
    tick();
    check("inv_fall_once", bus_b.fall_o, 3'b000);

`ifdef GPIO_IN_CONDITIONER_IRQ_EN
    clear("irq_clr_all", 3'b111);
    check("irq_idle", bus_a.irq_o, 0);
    settle("irq_ch0", 0, 1'b0, 1'b0);
    check("irq_masked_ch0", bus_a.irq_o, 0);
    settle("irq_ch1", 1, 1'b0, 1'b0);
    check("irq_ch1_same_cycle", bus_a.irq_o, 1);
    clear("irq_ch1_clr", 3'b010);
    check("irq_after_clr", bus_a.irq_o, 0);
    settle("irq_ch1_again", 1, 1'b1, 1'b0);
    check("irq_ch1_again", bus_a.irq_o, 1);
    bus_a.irq_mask_i = 3'b000;
    tick();
    check("irq_unmasked_drop", bus_a.irq_o, 0);
    check("irq_event_kept", bus_a.event_o, exp_event);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
Board-level input conditioner that sits between raw push-button pins and the zerosoc gpio_i bus. It is the input-side counterpart of the gpio_o-to-LED path.
- Synchronises each asynchronous pin into clk_i.
- Debounces each channel with a per-channel stability counter.
- Emits single-cycle rise/fall pulses.
- Holds sticky per-channel event flags that software-side logic clears explicitly.

Parameters:
NumInputs, 3, number of independent input channels.
DebounceCycles, 60000, consecutive stable cycles needed to accept a new level (10 ms at 6 MHz); legal range >= 1.
InvertInputs, 0, when 1 each raw pin is inverted before synchronisation (for active-low buttons).

Ports:
clk_i  input  1  system clock; the only clock.
rst_i  input  1  synchronous active-high reset.
raw_i  input  NumInputs  asynchronous raw pin levels.
stable_o  output  NumInputs  debounced level per channel.
rise_o  output  NumInputs  one-cycle pulse when stable_o goes 0->1.
fall_o  output  NumInputs  one-cycle pulse when stable_o goes 1->0.
event_o  output  NumInputs  sticky flag, set on any stable_o transition.
event_clr_i  input  NumInputs  per-channel clear for event_o.

Behaviour:
Reset and clocking
- One clock, one reset; reset is synchronous and active-high (clk_i, rst_i).
- While rst_i is high at a clk_i edge, the following all load 0: sync stages, counters, stable_o, rise_o, fall_o, event_o.
- Reset asserted mid-debounce discards the partial count. No pulse is generated by reset itself.

Synchroniser
- Two-flop synchroniser per channel. The pin value is XOR InvertInputs before the first flop.

Debounce
- Per-channel counter, width $clog2(DebounceCycles+1).
- Each edge, compare the sync output s with stable_o:
  - s == stable_o: counter <= 0.
  - s != stable_o and counter < DebounceCycles-1: counter <= counter+1.
  - s != stable_o and counter == DebounceCycles-1: stable_o <= s, counter <= 0.
- Any bounce (s returns to stable_o) before terminal count restarts the count from 0.
- Latency: if raw_i changes and stays constant, stable_o shows the new value exactly DebounceCycles+2 edges after the first edge that samples the new raw value.
- DebounceCycles=1: stable_o follows s with one cycle delay; glitches >= 1 cycle after sync pass through.

Edge pulses
- rise_o/fall_o are registered and high for exactly one cycle, the same cycle stable_o first shows the new value.
- rise_o and fall_o are never both high on one channel.

Sticky events
- event_o[i] <= 1 on the cycle rise_o[i] or fall_o[i] is generated.
- event_clr_i[i] high at an edge clears event_o[i].
- Set and clear in the same cycle: set wins (event_o stays 1).

General
- Channels are fully independent. Outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
Macro GPIO_IN_CONDITIONER_IRQ_EN.
- Defined:
  - Adds port irq_mask_i (input, NumInputs).
  - Adds port irq_o (output, 1), registered.
  - irq_o <= |(event_o_next & irq_mask_i), where event_o_next is the value event_o takes this edge, so irq_o rises in the same cycle as the event bit.
  - irq_o resets to 0.
  - Masking a pending event drops irq_o the next cycle, with event_o unchanged.
- Undefined: neither port exists; no IRQ logic is built.

Test Plan:
1. Reset: drive raw_i=3'b111, hold rst_i high 3 cycles -> all outputs 0 throughout; after release, stable_o=3'b111 at edge DebounceCycles+2; rise_o=3'b111 for one cycle; event_o=3'b111.
2. Clean press, DebounceCycles=4: raw_i[0] 0->1 and held -> stable_o[0]=1 exactly 6 edges after first sampling edge; rise_o[0] one cycle; fall_o stays 0.
3. Bounce, DebounceCycles=4: raw_i[1] toggles 1,0,1,0 every 2 cycles, then holds 1 -> no stable_o change during the toggling; stable_o[1] rises 6 edges after the final hold begins.
4. Sticky clear collision: event_o[2]=1; pulse event_clr_i[2] -> cleared next cycle. Then assert event_clr_i[2] in the same cycle a new fall_o[2] occurs -> event_o[2] stays 1.
5. InvertInputs=1: raw_i=3'b000 after reset -> stable_o=3'b111 after debounce; raw_i[0]=1 -> fall_o[0] pulse.
6. With GPIO_IN_CONDITIONER_IRQ_EN, irq_mask_i=3'b010: event on channel 0 only -> irq_o=0. Event on channel 1 -> irq_o=1 in the same cycle as event_o[1]. Then clear via event_clr_i[1] -> irq_o=0 the next cycle.
